ram_capture_ctrl: RTL
=====================

RAM_CAPTURE_CTRL -- requirements
Module: ram_capture_ctrl

Interface
REQ-001 SHALL have parameter P_NBITS_ADDR, default 8, meaning capture RAM address width; depth D = 2^P_NBITS_ADDR.
REQ-002 SHALL have parameter P_NBITS_DATA, default 14, meaning sample width.
REQ-003 SHALL have clk  in  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have arm  in  1  single-cycle pulse starting a capture.
REQ-006 SHALL have trig  in  1  trigger qualifier, sampled each cycle.
REQ-007 SHALL have n_post  in  P_NBITS_ADDR  post-trigger sample count, latched on accepted arm.
REQ-008 SHALL have adc  in  P_NBITS_DATA  sample stream, one new sample per clk.
REQ-009 SHALL have rd_req  in  1  single-cycle pulse starting readout.
REQ-010 SHALL have ram_d  out  P_NBITS_DATA  RAM write data, equal to adc delayed 0 cycles (combinational pass-through).
REQ-011 SHALL have ram_addr_in  out  P_NBITS_ADDR  RAM write address (wr_ptr).
REQ-012 SHALL have ram_we  out  1  RAM write enable.
REQ-013 SHALL have ram_addr_out  out  P_NBITS_ADDR  RAM read address (rd_ptr).
REQ-014 SHALL have ram_q  in  P_NBITS_DATA  RAM read data, valid 2 clk after ram_addr_out presented (registered address plus registered output).
REQ-015 SHALL have dout  out  P_NBITS_DATA  readout data; dout_valid  out  1; dout_last  out  1  final readout word.
REQ-016 SHALL have trig_addr  out  P_NBITS_ADDR  RAM address holding the trigger sample.
REQ-017 SHALL have busy  out  1  state not IDLE; done  out  1  state is DONE.

Function
REQ-018 SHALL implement states IDLE, PRE, POST, DONE, READ.
REQ-019 IDLE: ram_we=0; arm=1 -> PRE, wr_ptr<=0, fill<=0, n_post latched; arm ignored in all other states.
REQ-020 PRE: ram_we=1 every cycle; wr_ptr increments mod D; fill (P_NBITS_ADDR+1 bits) increments, saturating at D.
REQ-021 PRE with trig=1: current sample written, trig_addr<=wr_ptr; n_post=0 -> DONE, else -> POST with post_cnt<=n_post; trig ignored outside PRE.
REQ-022 POST: ram_we=1, wr_ptr/fill advance as in PRE; post_cnt decrements per write; write with post_cnt=1 is last -> DONE.
REQ-023 Post-trigger writes SHALL overwrite oldest pre-trigger samples once wr_ptr wraps; no stall, no overflow flag.
REQ-024 DONE: ram_we=0, done=1; rd_req=1 -> READ; rd_req ignored outside DONE.
REQ-025 READ start: rd_ptr<=(fill==D) ? wr_ptr : 0; words to read = fill; rd_ptr increments mod D per cycle until fill addresses issued.
REQ-026 dout_valid SHALL assert exactly 2 clk after each address issue, dout=ram_q, oldest sample first, fill consecutive cycles, no gaps.
REQ-027 dout_last SHALL assert with final dout_valid; next cycle -> IDLE, busy=0.
REQ-028 arm/trig/rd_req arriving in same cycle SHALL be resolved by current state only; one event per cycle acted on.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, wr_ptr=rd_ptr=0, fill=0, post_cnt=0, trig_addr=0, ram_we=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0.
REQ-030 rst during PRE/POST/READ SHALL abort; ram_we deasserts immediately; in-flight read words SHALL NOT emerge on dout_valid.
REQ-031 RAM contents SHALL NOT be cleared by this block.

Verification
REQ-032 D=256, arm, trig at 10th sample, n_post=5 -> 15 writes, trig_addr=9, done=1; readout 15 words addr 0..14, dout_last on 15th.
REQ-033 arm, 300 samples in PRE, trig, n_post=20 -> fill=256, readout starts at wr_ptr (320 mod 256=64), 256 words, oldest first.
REQ-034 n_post=0, trig on first PRE cycle -> 1 write, DONE next cycle, readout 1 word with dout_valid and dout_last same cycle.
REQ-035 rd_req during POST, arm during DONE, trig during DONE -> all ignored, state unchanged.
REQ-036 rst asserted mid-READ -> outputs zero same cycle, no further dout_valid; subsequent arm captures normally.

Source files
------------

// File: rtl/ram_capture_ctrl.sv
// Pre/post-trigger capture controller driving an external synchronous RAM, with an
// oldest-first readout that compensates for the RAM's two-cycle read latency.
module ram_capture_ctrl #(
  parameter int unsigned P_NBITS_ADDR = 8,
  parameter int unsigned P_NBITS_DATA = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    trig,
  input  logic [P_NBITS_ADDR-1:0] n_post,
  input  logic [P_NBITS_DATA-1:0] adc,
  input  logic                    rd_req,
  output logic [P_NBITS_DATA-1:0] ram_d,
  output logic [P_NBITS_ADDR-1:0] ram_addr_in,
  output logic                    ram_we,
  output logic [P_NBITS_ADDR-1:0] ram_addr_out,
  input  logic [P_NBITS_DATA-1:0] ram_q,
  output logic [P_NBITS_DATA-1:0] dout,
  output logic                    dout_valid,
  output logic                    dout_last,
  output logic [P_NBITS_ADDR-1:0] trig_addr,
  output logic                    busy,
  output logic                    done
);

  localparam logic [P_NBITS_ADDR-1:0] AddrOne  = P_NBITS_ADDR'(1);
  localparam logic [P_NBITS_ADDR:0]   FillOne  = (P_NBITS_ADDR + 1)'(1);
  localparam logic [P_NBITS_ADDR:0]   FillFull = {1'b1, {P_NBITS_ADDR{1'b0}}};

  typedef enum logic [2:0] {StIdle, StPre, StPost, StDone, StRead} state_e;

  state_e                  state_q, state_d;
  logic [P_NBITS_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_NBITS_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_NBITS_ADDR:0]   fill_q, fill_d;
  logic [P_NBITS_ADDR:0]   rd_cnt_q, rd_cnt_d;
  logic [P_NBITS_ADDR-1:0] post_cnt_q, post_cnt_d;
  logic [P_NBITS_ADDR-1:0] n_post_q, n_post_d;
  logic [P_NBITS_ADDR-1:0] trig_addr_q, trig_addr_d;
  logic [1:0]              vld_q, last_q;
  logic                    write, issue, issue_last;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    rd_cnt_d    = rd_cnt_q;
    post_cnt_d  = post_cnt_q;
    n_post_d    = n_post_q;
    trig_addr_d = trig_addr_q;
    write       = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;

    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d  = StPre;
          wr_ptr_d = '0;
          fill_d   = '0;
          n_post_d = n_post;
        end
      end
      StPre: begin
        write = 1'b1;
        if (trig) begin
          trig_addr_d = wr_ptr_q;
          if (n_post_q == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StPost;
            post_cnt_d = n_post_q;
          end
        end
      end
      StPost: begin
        write      = 1'b1;
        post_cnt_d = post_cnt_q - AddrOne;
        if (post_cnt_q == AddrOne) state_d = StDone;
      end
      StDone: begin
        if (rd_req) begin
          state_d  = StRead;
          // A full buffer has wrapped, so the oldest sample sits at the write pointer.
          rd_ptr_d = (fill_q == FillFull) ? wr_ptr_q : '0;
          rd_cnt_d = fill_q;
        end
      end
      StRead: begin
        if (rd_cnt_q != '0) begin
          issue      = 1'b1;
          issue_last = (rd_cnt_q == FillOne);
          rd_ptr_d   = rd_ptr_q + AddrOne;
          rd_cnt_d   = rd_cnt_q - FillOne;
        end
        if (last_q[1]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (write) begin
      wr_ptr_d = wr_ptr_q + AddrOne;
      if (fill_q != FillFull) fill_d = fill_q + FillOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      rd_cnt_q    <= '0;
      post_cnt_q  <= '0;
      n_post_q    <= '0;
      trig_addr_q <= '0;
      vld_q       <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      rd_cnt_q    <= rd_cnt_d;
      post_cnt_q  <= post_cnt_d;
      n_post_q    <= n_post_d;
      trig_addr_q <= trig_addr_d;
      // Two stages match the RAM's registered address plus registered output.
      vld_q       <= {vld_q[0], issue};
      last_q      <= {last_q[0], issue_last};
    end
  end

  assign ram_d        = adc;
  assign ram_addr_in  = wr_ptr_q;
  assign ram_we       = write;
  assign ram_addr_out = rd_ptr_q;
  assign dout_valid   = vld_q[1];
  assign dout_last    = last_q[1];
  assign dout         = vld_q[1] ? ram_q : '0;
  assign trig_addr    = trig_addr_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

endmodule
